slc3_mem_responder: RTL
=======================

Name: slc3_mem_responder

Overview:
Memory-side responder for the SLC-3 CPU's MAR/MDR bus. It answers CPU read (OE) and write (WE) requests against an on-chip word RAM with a programmable number of wait states, and signals completion with a one-cycle Mem_Ready pulse. Address 0xFFFF is memory-mapped I/O: reads return the switches and writes load the hex-display register. It sits between the datapath's MAR/MDR and the board I/O, in place of the external SRAM path.

Parameters:
DEPTH, 1024, RAM words; valid RAM addresses are 0..DEPTH-1 (power of two, at most 32768).
WAIT_STATES, 2, extra cycles inserted before each access commits (0..15).
IO_ADDR, 16'hFFFF, memory-mapped I/O address.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
ADDR  in  16  word address from MAR.
OE  in  1  read request, active-low.
WE  in  1  write request, active-low.
Data_from_CPU  in  16  write data from MDR.
Data_to_CPU  out  16  read data to the MDR input mux.
Switches  in  10  board switches.
Hex_Data  out  16  hex-display register; nibble i drives HEX digit i.
Mem_Ready  out  1  one-cycle completion pulse.
Busy  out  1  high from request acceptance until Mem_Ready.

Behaviour:
- Reset low: asynchronously force state IDLE, wait counter 0, Data_to_CPU 0x0000, Hex_Data 0x0000, Mem_Ready 0, Busy 0. RAM contents are not reset.
- Reset mid-operation aborts the access. A pending write is not committed.
- FSM states: IDLE, WAIT, ACCESS, DONE, HOLD.
- IDLE: at each edge, sample OE and WE.
  - If WE=0, accept a write. If both OE=0 and WE=0, the write wins.
  - Otherwise, if OE=0, accept a read.
  - On acceptance (edge N): latch ADDR, Data_from_CPU and the op; set Busy=1.
  - Go to WAIT with count=WAIT_STATES, or go directly to ACCESS when WAIT_STATES=0.
- WAIT: decrement the counter each edge; go to ACCESS on the edge where the count reaches 0. Request-line changes are ignored in this state.
- ACCESS, one cycle:
  - Write to an address in 0..DEPTH-1: commits to RAM at the exit edge (N+WAIT_STATES+1).
  - Write to IO_ADDR: loads Hex_Data instead of RAM.
  - Write to any other address: ignored.
  - Read: issues the RAM read address.
  - Then go to DONE.
- DONE, one cycle:
  - Mem_Ready=1 and Busy=0, both registered, first visible after edge N+WAIT_STATES+2.
  - For a read, Data_to_CPU loads at that same edge:
    - address in RAM range: RAM word;
    - IO_ADDR: {6'b0, Switches} sampled at the ACCESS edge;
    - any other address: 0x0000.
  - Writes leave Data_to_CPU unchanged.
  - Then go to HOLD.
- HOLD: wait until OE=1 and WE=1, then go to IDLE. A request held low is not repeated, so each assertion gets exactly one response.
- Data_to_CPU holds its value until the next read completes.
- The latched address is used throughout the access; ADDR changes after acceptance have no effect.
- Read-after-write to the same address returns the new data; no bypass is needed because accesses are serialized.
- RAM range check: the access is in range when ADDR < DEPTH. The RAM index is ADDR[$clog2(DEPTH)-1:0].

Decomposition:
- Package slc3_mem_pkg holds:
  - typedef enum logic [2:0] {IDLE, WAIT, ACCESS, DONE, HOLD} mem_state_t;
  - localparam IO_ADDR_DEFAULT = 16'hFFFF;
  - typedef logic [15:0] word_t.
- Sub-module slc3_sram_model: a single-port synchronous RAM with ports Clk, we, addr, din and registered dout, of depth DEPTH. Its contents may be initialised from a hex file for program load.
- The FSM, wait counter, address decode and I/O registers stay in slc3_mem_responder.

Test Plan:
All scenarios use WAIT_STATES=2, DEPTH=1024.
1. Reset: hold Reset=0 with OE=0 -> Data_to_CPU=0x0000, Hex_Data=0x0000, Mem_Ready=0, Busy=0. Release -> read accepted at the next edge, Mem_Ready at edge +4.
2. Write then read: write 0x1234 to 0x0010 via WE=0 -> Mem_Ready pulses once, 4 edges after acceptance. Then read 0x0010 via OE=0 -> Data_to_CPU=0x1234 with Mem_Ready.
3. I/O: write 0xBEEF to 0xFFFF -> Hex_Data=0xBEEF, RAM[0x3FF] unchanged. Read 0xFFFF with Switches=10'h2A5 -> Data_to_CPU=0x02A5.
4. Boundaries:
   - read 0x0400 (out of range) -> 0x0000;
   - write 0x0400 -> no RAM change (RAM[0x000] unchanged);
   - simultaneous OE=0, WE=0 -> treated as a write.
5. Hold/abort:
   - keep OE=0 for 20 cycles -> exactly one Mem_Ready;
   - assert Reset=0 during WAIT of a write to 0x0020 -> RAM[0x0020] keeps its old value, outputs reset immediately.
6. WAIT_STATES=0 instance: read accepted at edge N -> Mem_Ready and data after edge N+2; ADDR changed after acceptance is ignored.

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory responder.
package slc3_mem_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, DONE, HOLD} mem_state_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

  typedef logic [15:0] word_t;

endpackage

// File: rtl/slc3_sram_model.sv
// Single-port synchronous word RAM with registered read data.
// Program images are loaded into the mem array by the memory-init flow.
module slc3_sram_model
  import slc3_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  word_t         din,
  output word_t         dout
);

  word_t mem [DEPTH];

  // Write on we; read port always returns the pre-write word at addr.
  always_ff @(posedge Clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC-3 MAR/MDR bus: word RAM plus the
// 0xFFFF switch/hex I/O register, with programmable wait states and a
// one-cycle Mem_Ready completion pulse.
module slc3_mem_responder
  import slc3_mem_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic        OE,
  input  logic        WE,
  input  logic [15:0] Data_from_CPU,
  output logic [15:0] Data_to_CPU,
  input  logic [9:0]  Switches,
  output logic [15:0] Hex_Data,
  output logic        Mem_Ready,
  output logic        Busy
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] WS      = 4'(WAIT_STATES);
  localparam logic [16:0] DEPTH17 = 17'(DEPTH);

  mem_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  word_t       addr_q, addr_d;
  word_t       wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [9:0]  sw_q, sw_d;
  word_t       rdata_q, rdata_d;
  word_t       hex_q, hex_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;

  logic        ram_we;
  word_t       ram_dout;
  logic        in_ram;
  logic        is_io;

  // Decode always uses the latched address, never the live bus.
  assign in_ram = ({1'b0, addr_q} < DEPTH17);
  assign is_io  = (addr_q == IO_ADDR);

  slc3_sram_model #(.DEPTH(DEPTH)) u_ram (
    .Clk  (Clk),
    .we   (ram_we),
    .addr (addr_q[AW-1:0]),
    .din  (wdata_q),
    .dout (ram_dout)
  );

  // Next-state and datapath control for the access sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    sw_d    = sw_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;
    rdy_d   = 1'b0;
    busy_d  = busy_q;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        // Write wins when both strobes are low.
        if (!WE || !OE) begin
          addr_d  = ADDR;
          wdata_d = Data_from_CPU;
          wr_d    = !WE;
          busy_d  = 1'b1;
          cnt_d   = WS;
          state_d = (WAIT_STATES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ACCESS;
      end
      ACCESS: begin
        ram_we = wr_q && in_ram;
        if (wr_q && is_io) hex_d = wdata_q;
        sw_d    = Switches;
        state_d = DONE;
      end
      DONE: begin
        rdy_d  = 1'b1;
        busy_d = 1'b0;
        if (!wr_q) begin
          if (in_ram)     rdata_d = ram_dout;
          else if (is_io) rdata_d = {6'b0, sw_q};
          else            rdata_d = 16'h0000;
        end
        state_d = HOLD;
      end
      HOLD: begin
        // One response per strobe assertion: wait for both to go high.
        if (OE && WE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      wr_q    <= 1'b0;
      sw_q    <= 10'd0;
      rdata_q <= 16'h0000;
      hex_q   <= 16'h0000;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      sw_q    <= sw_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign Data_to_CPU = rdata_q;
  assign Hex_Data    = hex_q;
  assign Mem_Ready   = rdy_q;
  assign Busy        = busy_q;

endmodule
